sobol_stream_sched: RTL and testbench
=====================================

Name: sobol_stream_sched

Overview:
- Round-robin scheduler that shares one Sobol RNG instance (counter + LSZ + core) between NUM_REQ requesters.
- Each granted request gets a full, freshly restarted Sobol sequence of 2^LEN_LOG2 values.
- Each value is compared against the requester's latched operand to produce a unary (stochastic) bitstream, a ones count and a done pulse.
- Sits between the bitstream-consuming compute units and the shared sobolrng datapath, and drives that datapath's enable and reset.

Parameters:
- BITWIDTH, 8, width of operands and of RNG output; same meaning as the codebase-wide `BITWIDTH.
- NUM_REQ, 4, number of requesters (1..16).
- LEN_LOG2, BITWIDTH, log2 of stream length; legal range 1..BITWIDTH.
- IDW, clog2(NUM_REQ) (min 1), width of requester id.

Ports:
- iClk  in  1  clock
- iRst  in  1  synchronous active-high reset
- iReqVld  in  NUM_REQ  per-requester request; level, held until granted
- iReqData  in  NUM_REQ*BITWIDTH  packed operands; requester k occupies bits [k*BITWIDTH +: BITWIDTH]
- oReqRdy  out  NUM_REQ  one-hot grant/accept pulse
- iRand  in  BITWIDTH  RNG output (sobolSeq)
- oRngEn  out  1  RNG enable (drives iEn)
- oRngRstN  out  1  RNG active-low clear (drives iRstN)
- iStall  in  1  consumer backpressure; pauses the stream
- oBit  out  1  stream bit
- oBitVld  out  1  oBit valid
- oBitId  out  IDW  id of the requester currently owning the stream
- oOnes  out  LEN_LOG2+1  running ones count
- oDone  out  1  one-cycle end-of-stream pulse
- oBusy  out  1  high in CLR/RUN/DONE

Behaviour:
- Clocking and reset: one clock iClk; iRst is synchronous and active-high. All state and outputs are registered except oReqRdy, oRngEn and oRngRstN, which decode the current state.
- Reset values: state=IDLE, rr pointer=NUM_REQ-1 (so requester 0 has first priority), cnt=0, operand=0, oBit=0, oBitVld=0, oBitId=0, oOnes=0, oDone=0, oBusy=0, oReqRdy=0, oRngEn=0. oRngRstN=0 while iRst is high.
- Reset mid-stream aborts immediately: no oDone, the RNG is cleared, and the abandoned requester is not re-granted automatically.
- IDLE:
  - If any iReqVld bit is set, grant the first set bit searching from ptr+1 upward with wrap.
  - oReqRdy[g]=1 combinationally in this cycle; at the edge latch operand=iReqData[g], oBitId=g, ptr=g, oOnes=0, then go to CLR.
  - If no request, stay in IDLE with all outputs idle.
  - A requester dropping iReqVld before grant is legal and is simply not granted.
- CLR (1 cycle): oRngRstN=0, oRngEn=0, cnt=0, then go to RUN.
- RUN:
  - oRngRstN=1; oRngEn = ~iStall.
  - In every non-stalled cycle: sample iRand; at the edge oBit <= (iRand < operand) unsigned, oBitVld <= 1, oOnes += that bit, cnt += 1.
  - A stalled cycle: oBitVld <= 0 and cnt, oOnes and the RNG are held.
  - The non-stalled cycle with cnt == 2^LEN_LOG2-1 goes to DONE.
  - RNG contract: in the first non-stalled RUN cycle, iRand is sequence element 0 (=0); each enabled edge advances it by one element.
- DONE (1 cycle):
  - oBit/oBitVld show the final bit (registered from the last RUN cycle); oOnes is final; oDone=1; oRngEn=0.
  - Next state IDLE; oBitVld and oDone return to 0 in the following cycle.
  - oBitId and oOnes hold until the next grant.
- Throughput: one stream costs 1 (IDLE) + 1 (CLR) + 2^LEN_LOG2 + stalls + 1 (DONE) cycles. Requests arriving while busy wait. iStall is ignored outside RUN.
- Widths:
  - cnt has LEN_LOG2+1 bits and must not wrap within a stream.
  - oOnes max is 2^LEN_LOG2.
  - Operand 0 yields an all-zero stream; operand 2^BITWIDTH-1 with LEN_LOG2=BITWIDTH yields 2^BITWIDTH-1 ones.
- Accuracy: with LEN_LOG2=BITWIDTH the first Sobol dimension is a permutation of 0..2^BITWIDTH-1, so the final oOnes must equal the operand exactly.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0,...; no requester waits more than NUM_REQ-1 streams.

Test Plan:
- BITWIDTH=8, NUM_REQ=4, req0 operand 100, no stall -> oReqRdy=0001 pulse, oRngRstN low 1 cycle, 256 oBitVld cycles, oDone one cycle after last RUN cycle, oOnes=100, oBitId=0.
- Operands 0 and 255 (single requester) -> oOnes=0 (all bits 0) and oOnes=255 respectively; exactly 256 valid bits each.
- All four requesters held high with operands 10,20,30,40 -> grant order 0,1,2,3,0; oOnes matches each operand; oBitId tracks the owner; gap of exactly one IDLE cycle between DONE and the next CLR.
- Operand 77 with iStall random at 50% during RUN -> oRngEn low on stalled cycles, no oBitVld for them, total valid bits 256, oOnes=77, bit sequence identical to the unstalled run.
- iRst asserted mid-RUN (cycle 40) while req2 is busy -> next cycle IDLE, all outputs at reset values, oRngRstN=0 during reset, no oDone; after release with req1 and req2 both pending, req0 priority ptr restarts and req1 is granted first.
- LEN_LOG2=4, BITWIDTH=8, operand 128 -> exactly 16 valid bits, oDone after the 16th, oOnes=8.

Source files
------------

// File: rtl/sobol_stream_sched.sv
// rtl/sobol_stream_sched.sv - round-robin scheduler sharing one Sobol RNG among requesters
// Each grant restarts the RNG and emits 2^LEN_LOG2 unary bits (iRand < operand) plus a ones count.
module sobol_stream_sched #(
  parameter int BITWIDTH = 8,
  parameter int NUM_REQ  = 4,
  parameter int LEN_LOG2 = BITWIDTH,
  parameter int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic [NUM_REQ-1:0]           iReqVld,
  input  logic [NUM_REQ*BITWIDTH-1:0]  iReqData,
  output logic [NUM_REQ-1:0]           oReqRdy,
  input  logic [BITWIDTH-1:0]          iRand,
  output logic                         oRngEn,
  output logic                         oRngRstN,
  input  logic                         iStall,
  output logic                         oBit,
  output logic                         oBitVld,
  output logic [IDW-1:0]               oBitId,
  output logic [LEN_LOG2:0]            oOnes,
  output logic                         oDone,
  output logic                         oBusy
);
  localparam int CW = LEN_LOG2 + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((1 << LEN_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} stateT;

  stateT               state, stateNxt;
  logic [IDW-1:0]      ptr, grantIdx, candIdx;
  logic                grantVld;
  logic [CW-1:0]       cnt;
  logic [BITWIDTH-1:0] operand;
  logic                runBit;

  // Scan from the farthest candidate down so the nearest set bit after ptr wins.
  always_comb begin : arbiter
    grantVld = 1'b0;
    grantIdx = '0;
    candIdx  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      candIdx = IDW'((int'(ptr) + i) % NUM_REQ);
      if (iReqVld[candIdx]) begin
        grantVld = 1'b1;
        grantIdx = candIdx;
      end
    end
  end

  assign runBit = (iRand < operand);

  always_comb begin : fsmComb
    stateNxt = state;
    oReqRdy  = '0;
    oRngEn   = 1'b0;
    oRngRstN = ~iRst;
    case (state)
      IDLE: begin
        if (grantVld && !iRst) begin
          oReqRdy  = NUM_REQ'(1) << grantIdx;
          stateNxt = CLR;
        end
      end
      CLR: begin
        oRngRstN = 1'b0;
        stateNxt = RUN;
      end
      RUN: begin
        oRngEn = ~iStall & ~iRst;
        if (!iStall && cnt == LAST_CNT) stateNxt = DONE;
      end
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= IDLE;
      ptr     <= IDW'(NUM_REQ - 1);
      cnt     <= '0;
      operand <= '0;
      oBit    <= 1'b0;
      oBitVld <= 1'b0;
      oBitId  <= '0;
      oOnes   <= '0;
      oDone   <= 1'b0;
      oBusy   <= 1'b0;
    end else begin
      state   <= stateNxt;
      oBitVld <= 1'b0;
      oDone   <= 1'b0;
      case (state)
        IDLE: begin
          if (grantVld) begin
            operand <= iReqData[int'(grantIdx)*BITWIDTH +: BITWIDTH];
            oBitId  <= grantIdx;
            ptr     <= grantIdx;
            oOnes   <= '0;
            oBusy   <= 1'b1;
          end
        end
        CLR: cnt <= '0;
        RUN: begin
          if (!iStall) begin
            oBit    <= runBit;
            oBitVld <= 1'b1;
            oOnes   <= oOnes + CW'(runBit);
            cnt     <= cnt + CW'(1);
            // oDone lands in DONE together with the final registered bit.
            if (cnt == LAST_CNT) oDone <= 1'b1;
          end
        end
        DONE:    oBusy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sobol_stream_sched.sv
// tb/tb_sobol_stream_sched.sv - randomized self-checking bench for sobol_stream_sched
module tb_sobol_stream_sched;
  localparam int BW = 8;
  localparam int NR = 4;
  localparam int L  = 256;
  localparam int SL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall, rngEn, rngRstN, bitOut, bitVld, done, busy;
  logic [NR-1:0] reqVld, reqRdy;
  logic [NR*BW-1:0] reqData;
  logic [BW-1:0] rnd;
  logic [1:0] bitId;
  logic [8:0] ones;

  logic sStall, sRngEn, sRngRstN, sBit, sBitVld, sDone, sBusy;
  logic [NR-1:0] sReqVld, sReqRdy;
  logic [NR*BW-1:0] sReqData;
  logic [BW-1:0] sRnd;
  logic [1:0] sBitId;
  logic [4:0] sOnes;

  int checks = 0;
  int errors = 0;

  sobol_stream_sched #(.BITWIDTH(BW), .NUM_REQ(NR), .LEN_LOG2(8)) dut (
    .iClk(clk), .iRst(rst), .iReqVld(reqVld), .iReqData(reqData), .oReqRdy(reqRdy),
    .iRand(rnd), .oRngEn(rngEn), .oRngRstN(rngRstN), .iStall(stall), .oBit(bitOut),
    .oBitVld(bitVld), .oBitId(bitId), .oOnes(ones), .oDone(done), .oBusy(busy));

  sobol_stream_sched #(.BITWIDTH(BW), .NUM_REQ(NR), .LEN_LOG2(4)) dutShort (
    .iClk(clk), .iRst(rst), .iReqVld(sReqVld), .iReqData(sReqData), .oReqRdy(sReqRdy),
    .iRand(sRnd), .oRngEn(sRngEn), .oRngRstN(sRngRstN), .iStall(sStall), .oBit(sBit),
    .oBitVld(sBitVld), .oBitId(sBitId), .oOnes(sOnes), .oDone(sDone), .oBusy(sBusy));

  // First Sobol dimension: element n is the bit-reversed Gray code of n.
  function automatic logic [BW-1:0] sobol(input int n);
    logic [BW-1:0] g, r;
    g = BW'(n ^ (n >> 1));
    for (int b = 0; b < BW; b++) r[b] = g[BW-1-b];
    return r;
  endfunction

  function automatic int expOnes(input int op, input int len);
    int c = 0;
    for (int k = 0; k < len; k++) if (int'(sobol(k)) < op) c++;
    return c;
  endfunction

  int rngCnt = 0, sRngCnt = 0;
  always @(posedge clk) begin
    if (!rngRstN) rngCnt <= 0; else if (rngEn) rngCnt <= rngCnt + 1;
    if (!sRngRstN) sRngCnt <= 0; else if (sRngEn) sRngCnt <= sRngCnt + 1;
  end
  assign rnd  = sobol(rngCnt);
  assign sRnd = sobol(sRngCnt);

  // Observes one stream on the main instance; cycle 0 is the grant cycle.
  task automatic capture(input bit keepReq, input bit stallEn,
      output int gId, output logic [NR-1:0] rdyVal, output int waitCyc,
      output int nValid, output logic [L-1:0] bits, output int rstLow, output int enCnt,
      output int stallViol, output int stallRun, output int doneIdx, output bit doneVld,
      output int doneId, output int doneOnes, output bit stray, output bit to);
    gId = -1; rdyVal = '0; waitCyc = 0; nValid = 0; bits = '0; rstLow = 0; enCnt = 0;
    stallViol = 0; stallRun = 0; doneIdx = -1; doneVld = 0; doneId = -1; doneOnes = -1;
    stray = 0; to = 0;
    stall = 1'b0;
    #1;
    while (reqRdy == '0) begin
      @(negedge clk); #1;
      waitCyc++;
      if (done || bitVld) stray = 1;
      if (waitCyc > 50) begin to = 1; return; end
    end
    rdyVal = reqRdy;
    for (int i = 0; i < NR; i++) if (reqRdy[i]) gId = i;
    for (int c = 1; c < 2000; c++) begin
      @(negedge clk);
      if (c == 1 && !keepReq) reqVld[gId] = 1'b0;
      stall = stallEn ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (!rngRstN) rstLow++;
      if (rngEn) enCnt++;
      if (stall && rngEn) stallViol++;
      if (c >= 2 && !done && stall) stallRun++;
      if (bitVld) begin
        if (nValid < L) bits[nValid] = bitOut;
        nValid++;
      end
      if (done) begin
        doneIdx = c; doneVld = bitVld; doneId = int'(bitId); doneOnes = int'(ones);
        stall = 1'b0;
        return;
      end
    end
    to = 1;
  endtask

  function automatic int bitErrs(input logic [L-1:0] bits, input int op);
    int bad = 0;
    for (int k = 0; k < L; k++) if (bits[k] !== (int'(sobol(k)) < op)) bad++;
    return bad;
  endfunction

  int gId, waitCyc, nValid, rstLow, enCnt, stallViol, stallRun, doneIdx, doneId, doneOnes;
  logic [NR-1:0] rdyVal;
  logic [L-1:0] bits;
  bit doneVld, stray, to;

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; sStall = 1'b0;
    reqVld = '0; reqData = '0; sReqVld = '0; sReqData = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (reqRdy !== 4'b0000) begin errors++; $display("FAIL rst_reqRdy got %b exp 0000", reqRdy); end
    checks++; if (rngEn !== 1'b0) begin errors++; $display("FAIL rst_rngEn got %b exp 0", rngEn); end
    checks++; if (rngRstN !== 1'b0) begin errors++; $display("FAIL rst_rngRstN got %b exp 0", rngRstN); end
    checks++; if ({bitOut, bitVld, done, busy} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b exp 0000", {bitOut, bitVld, done, busy}); end
    checks++; if (ones !== 9'd0) begin errors++; $display("FAIL rst_ones got %0d exp 0", ones); end
    checks++; if (bitId !== 2'd0) begin errors++; $display("FAIL rst_bitId got %0d exp 0", bitId); end
    checks++; if ({sBusy, sDone, sBitVld} !== 3'b0) begin errors++; $display("FAIL rst_short got %b exp 000", {sBusy, sDone, sBitVld}); end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if ({rngRstN, busy} !== 2'b10) begin errors++; $display("FAIL idle_rng got %b exp 10", {rngRstN, busy}); end
  endtask

  task automatic test_fairness();
    int ops[NR] = '{10, 20, 30, 40};
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NR; i++) reqData[i*BW +: BW] = BW'(ops[i]);
    reqVld = '1;
    for (int s = 0; s < 5; s++) begin
      capture(1'b1, 1'b0, gId, rdyVal, waitCyc, nValid, bits, rstLow, enCnt, stallViol,
              stallRun, doneIdx, doneVld, doneId, doneOnes, stray, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL fair_timeout stream %0d got %b exp 0", s, to); end
      checks++; if (gId !== s % NR) begin errors++; $display("FAIL fair_order stream %0d got %0d exp %0d", s, gId, s % NR); end
      checks++; if (doneId !== s % NR) begin errors++; $display("FAIL fair_bitId stream %0d got %0d exp %0d", s, doneId, s % NR); end
      checks++; if (doneOnes !== expOnes(ops[s % NR], L)) begin errors++; $display("FAIL fair_ones stream %0d got %0d exp %0d", s, doneOnes, expOnes(ops[s % NR], L)); end
      if (s > 0) begin
        checks++; if (waitCyc !== 1 || stray) begin errors++; $display("FAIL fair_gap stream %0d got wait %0d stray %b exp wait 1 stray 0", s, waitCyc, stray); end
      end
    end
    reqVld = '0;
    @(negedge clk); #1;
  endtask

  task automatic test_basic();
    reqData = '0; reqData[0 +: BW] = 8'd100; reqVld = 4'b0001;
    capture(1'b0, 1'b0, gId, rdyVal, waitCyc, nValid, bits, rstLow, enCnt, stallViol,
            stallRun, doneIdx, doneVld, doneId, doneOnes, stray, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b exp 0", to); end
    checks++; if (rdyVal !== 4'b0001) begin errors++; $display("FAIL basic_reqRdy got %b exp 0001", rdyVal); end
    checks++; if (rstLow !== 1) begin errors++; $display("FAIL basic_rngRstN_low got %0d exp 1", rstLow); end
    checks++; if (enCnt !== L) begin errors++; $display("FAIL basic_rngEn_cycles got %0d exp %0d", enCnt, L); end
    checks++; if (nValid !== L) begin errors++; $display("FAIL basic_nvalid got %0d exp %0d", nValid, L); end
    checks++; if (bitErrs(bits, 100) !== 0) begin errors++; $display("FAIL basic_bits got %0d wrong exp 0", bitErrs(bits, 100)); end
    checks++; if (doneOnes !== 100) begin errors++; $display("FAIL basic_ones got %0d exp 100", doneOnes); end
    checks++; if (doneIdx !== 2 + L || doneVld !== 1'b1) begin errors++; $display("FAIL basic_done_timing got idx %0d vld %b exp idx %0d vld 1", doneIdx, doneVld, 2 + L); end
    checks++; if (doneId !== 0) begin errors++; $display("FAIL basic_bitId got %0d exp 0", doneId); end
    @(negedge clk); #1;
    checks++; if ({done, bitVld, busy} !== 3'b000 || ones !== 9'd100 || bitId !== 2'd0) begin
      errors++; $display("FAIL basic_after got dvb %b ones %0d id %0d exp 000 100 0", {done, bitVld, busy}, ones, bitId); end
  endtask

  task automatic test_extremes();
    int ops[3];
    int r;
    ops[0] = 0; ops[1] = 255; ops[2] = int'($urandom_range(1, 254));
    for (int t = 0; t < 3; t++) begin
      r = int'($urandom_range(0, NR - 1));
      reqData = '0; reqData[r*BW +: BW] = BW'(ops[t]);
      reqVld = '0; reqVld[r] = 1'b1;
      capture(1'b0, 1'b0, gId, rdyVal, waitCyc, nValid, bits, rstLow, enCnt, stallViol,
              stallRun, doneIdx, doneVld, doneId, doneOnes, stray, to);
      checks++; if (to !== 1'b0 || gId !== r) begin errors++; $display("FAIL ext_grant op %0d got %0d exp %0d", ops[t], gId, r); end
      checks++; if (nValid !== L) begin errors++; $display("FAIL ext_nvalid op %0d got %0d exp %0d", ops[t], nValid, L); end
      checks++; if (doneOnes !== expOnes(ops[t], L)) begin errors++; $display("FAIL ext_ones op %0d got %0d exp %0d", ops[t], doneOnes, expOnes(ops[t], L)); end
      checks++; if (bitErrs(bits, ops[t]) !== 0) begin errors++; $display("FAIL ext_bits op %0d got %0d wrong exp 0", ops[t], bitErrs(bits, ops[t])); end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_stall();
    int ops[2];
    ops[0] = 77; ops[1] = int'($urandom_range(0, 255));
    for (int t = 0; t < 2; t++) begin
      reqData = '0; reqData[3*BW +: BW] = BW'(ops[t]); reqVld = 4'b1000;
      capture(1'b0, 1'b1, gId, rdyVal, waitCyc, nValid, bits, rstLow, enCnt, stallViol,
              stallRun, doneIdx, doneVld, doneId, doneOnes, stray, to);
      checks++; if (to !== 1'b0 || gId !== 3) begin errors++; $display("FAIL stall_grant got %0d exp 3", gId); end
      checks++; if (stallViol !== 0) begin errors++; $display("FAIL stall_rngEn got %0d enabled stall cycles exp 0", stallViol); end
      checks++; if (nValid !== L) begin errors++; $display("FAIL stall_nvalid got %0d exp %0d", nValid, L); end
      checks++; if (doneOnes !== expOnes(ops[t], L)) begin errors++; $display("FAIL stall_ones got %0d exp %0d", doneOnes, expOnes(ops[t], L)); end
      checks++; if (bitErrs(bits, ops[t]) !== 0) begin errors++; $display("FAIL stall_bits got %0d wrong exp 0", bitErrs(bits, ops[t])); end
      checks++; if (doneIdx !== 2 + L + stallRun) begin errors++; $display("FAIL stall_done_timing got %0d exp %0d", doneIdx, 2 + L + stallRun); end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    int op1, op2, w;
    op1 = int'($urandom_range(0, 255)); op2 = int'($urandom_range(0, 255));
    reqData = '0;
    reqData[1*BW +: BW] = BW'(op1); reqData[2*BW +: BW] = BW'(op2);
    reqVld = 4'b0100;
    #1;
    for (w = 0; w < 20 && reqRdy == '0; w++) begin @(negedge clk); #1; end
    checks++; if (reqRdy !== 4'b0100) begin errors++; $display("FAIL mrst_grant got %b exp 0100", reqRdy); end
    for (int c = 1; c <= 41; c++) begin @(negedge clk); #1; end
    checks++; if ({busy, bitVld} !== 2'b11) begin errors++; $display("FAIL mrst_running got %b exp 11", {busy, bitVld}); end
    rst = 1'b1; reqVld = 4'b0110;
    @(negedge clk); #1;
    checks++; if ({busy, bitVld, done, bitOut, rngEn, rngRstN} !== 6'b0) begin
      errors++; $display("FAIL mrst_flags got %b exp 000000", {busy, bitVld, done, bitOut, rngEn, rngRstN}); end
    checks++; if (ones !== 9'd0 || bitId !== 2'd0 || reqRdy !== 4'b0) begin
      errors++; $display("FAIL mrst_state got ones %0d id %0d rdy %b exp 0 0 0000", ones, bitId, reqRdy); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mrst_nodone got %b exp 0", done); end
    rst = 1'b0;
    capture(1'b0, 1'b0, gId, rdyVal, waitCyc, nValid, bits, rstLow, enCnt, stallViol,
            stallRun, doneIdx, doneVld, doneId, doneOnes, stray, to);
    checks++; if (to !== 1'b0 || gId !== 1) begin errors++; $display("FAIL mrst_first got %0d exp 1", gId); end
    checks++; if (doneOnes !== expOnes(op1, L)) begin errors++; $display("FAIL mrst_ones1 got %0d exp %0d", doneOnes, expOnes(op1, L)); end
    capture(1'b0, 1'b0, gId, rdyVal, waitCyc, nValid, bits, rstLow, enCnt, stallViol,
            stallRun, doneIdx, doneVld, doneId, doneOnes, stray, to);
    checks++; if (to !== 1'b0 || gId !== 2) begin errors++; $display("FAIL mrst_second got %0d exp 2", gId); end
    checks++; if (doneOnes !== expOnes(op2, L)) begin errors++; $display("FAIL mrst_ones2 got %0d exp %0d", doneOnes, expOnes(op2, L)); end
    @(negedge clk); #1;
  endtask

  task automatic test_short_stream();
    int ops[2];
    int g, nV, doneAt, nAtDone, dOnes;
    bit dVld;
    ops[0] = 128; ops[1] = int'($urandom_range(0, 255));
    for (int t = 0; t < 2; t++) begin
      g = -1; nV = 0; doneAt = -1; nAtDone = -1; dOnes = -1; dVld = 0;
      sReqData = '0; sReqData[0 +: BW] = BW'(ops[t]); sReqVld = 4'b0001;
      #1;
      for (int c = 0; c < 100; c++) begin
        if (g < 0 && sReqRdy != '0) g = c;
        if (g >= 0 && c == g + 1) sReqVld = '0;
        if (sBitVld) nV++;
        if (sDone) begin doneAt = c - g; dVld = sBitVld; dOnes = int'(sOnes); nAtDone = nV; break; end
        @(negedge clk); #1;
      end
      checks++; if (g < 0 || doneAt !== 2 + SL) begin errors++; $display("FAIL short_done_timing op %0d got %0d exp %0d", ops[t], doneAt, 2 + SL); end
      checks++; if (nAtDone !== SL || dVld !== 1'b1) begin errors++; $display("FAIL short_nvalid op %0d got %0d vld %b exp %0d vld 1", ops[t], nAtDone, dVld, SL); end
      checks++; if (dOnes !== expOnes(ops[t], SL)) begin errors++; $display("FAIL short_ones op %0d got %0d exp %0d", ops[t], dOnes, expOnes(ops[t], SL)); end
      @(negedge clk); #1;
      checks++; if ({sDone, sBitVld, sBusy} !== 3'b000) begin errors++; $display("FAIL short_after got %b exp 000", {sDone, sBitVld, sBusy}); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fairness();
    test_basic();
    test_extremes();
    test_stall();
    test_mid_reset();
    test_short_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
